dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Direct-mapped, write-back, write-allocate L1 data cache controller between the CPU MEM stage (EX_MEM outputs) and the 256-bit off-chip data memory port (mem_* signals). It replaces the direct Data_Memory hookup. It serves 32-bit loads and stores from an internal line array. On a miss it stalls the pipeline, writes back a dirty victim if there is one, and refills the line with one 256-bit transaction.

## Interface
- LINES, 32: number of cache lines; power of two. Index width IW = log2(LINES).
- Address split for LINES=32:
  - [4:2] word within the line.
  - [9:5] index.
  - [31:10] tag, TW = 32-5-IW bits.
  - [1:0] ignored.

- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- cpu_req_i  in  1  MEM-stage access valid (MemRead | MemWrite).
- cpu_write_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  32  byte address (EX_MEM ALU result).
- cpu_data_i  in  32  store data.
- cpu_data_o  out  32  load data, combinational from the array.
- cpu_stall_o  out  1  pipeline freeze request.
- mem_data_i  in  256  refill line.
- mem_ack_i  in  1  one-cycle completion pulse from memory.
- mem_data_o  out  256  write-back line.
- mem_addr_o  out  32  line address; bits [4:0] are always 0.
- mem_enable_o  out  1  memory request.
- mem_write_o  out  1  1 = write-back, 0 = refill.

## Operation
- Storage:
  - data[LINES] of 256 bits; word w occupies bits [32w+31:32w].
  - tag[LINES] of TW bits.
  - valid[LINES] and dirty[LINES].
  - On reset, valid and dirty are cleared. Data and tag are not reset.
- hit = cpu_req_i & valid[idx] & (tag[idx] == addr tag).
- cpu_data_o = data[idx] word[w] whenever state is IDLE. Value is don't-care when there is no hit.
- cpu_stall_o = cpu_req_i & ~hit while state is IDLE; it is 1 in every other state.
- While cpu_stall_o is 1, the CPU holds cpu_* inputs stable.
- Store hit in IDLE: at the clock edge, write word w of data[idx] and set dirty[idx]=1.
- FSM, with a registered state:
  - IDLE
    - Miss with valid & dirty victim -> WRITEBACK.
    - Otherwise miss -> ALLOCATE.
    - Hit or no request -> IDLE.
  - WRITEBACK
    - Drives mem_enable_o=1, mem_write_o=1, mem_addr_o={tag[idx], idx, 5'b0}, mem_data_o=data[idx].
    - On mem_ack_i: clear dirty[idx], go to GAP.
  - GAP
    - Drives mem_enable_o=0 for one cycle, then -> ALLOCATE.
  - ALLOCATE
    - Drives mem_enable_o=1, mem_write_o=0, mem_addr_o={cpu tag, idx, 5'b0}.
    - On mem_ack_i: data[idx] <= mem_data_i, tag[idx] <= cpu tag, valid=1, dirty=0. Go to IDLE.
- After refill the access replays in IDLE as a hit. A store miss performs its store write then, which sets dirty.
- mem_enable_o and mem_write_o are decoded from the state register (glitch-free). Both are 0 in IDLE and GAP.
- mem_data_o = 0 outside WRITEBACK. mem_addr_o = 0 in IDLE and GAP.
- mem_ack_i in IDLE or GAP is ignored.
- A request with cpu_req_i=0 never changes any state.

## Timing
- Reset values: state IDLE, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, cpu_stall_o=cpu_req_i (every line invalid).
- Hit: zero stall cycles. Load data is valid in the same cycle; store commits at that cycle's edge.
- Clean miss:
  - Cycle 0: miss detected, stall=1.
  - Cycles 1..k: mem_enable_o=1, with ack in cycle k.
  - Cycle k+1: IDLE hit, stall=0.
  - Total stall cycles = k+1.
- Dirty miss: write-back ack at cycle j, GAP at j+1, ALLOCATE from j+2 until its ack at cycle m, IDLE hit at m+1.
- mem_ack_i is a single-cycle pulse. The controller samples it only in WRITEBACK/ALLOCATE. mem_enable_o falls in the cycle after ack.
- Reset asserted mid-transaction: state returns to IDLE immediately and asynchronously, mem_enable_o drops, and all lines are invalidated. A partially completed refill is discarded.

## Test plan
- Reset:
  - Stimulus: assert rst_i=0 mid-ALLOCATE, then release.
  - Required: mem_enable_o=0 at once; next request to 0x44 misses again with mem_addr_o=0x40.
- Clean read miss:
  - Stimulus: load 0x44, memory acks on the 3rd enable cycle with line word1=0xDEADBEEF.
  - Required: stall for 4 cycles, mem_addr_o=0x40, mem_write_o=0; then cpu_data_o=0xDEADBEEF with stall=0.
- Read hit:
  - Stimulus: load 0x40 right after the refill above.
  - Required: no stall, mem_enable_o stays 0, cpu_data_o equals line word0.
- Store hit then conflict miss:
  - Stimulus: store 0x12345678 to 0x44, then load 0x444 (same index 2, tag 1).
  - Required:
    - WRITEBACK first: mem_write_o=1, mem_addr_o=0x40, mem_data_o bits[63:32]=0x12345678.
    - Then one GAP cycle with enable 0.
    - Then ALLOCATE: mem_addr_o=0x440, mem_write_o=0.
- Store miss:
  - Stimulus: store 0xA5A5A5A5 to 0x84 with the line invalid.
  - Required: refill from 0x80; after IDLE, a load of 0x84 returns 0xA5A5A5A5. A later conflicting miss writes back 0x80 (dirty).
- Spurious ack:
  - Stimulus: pulse mem_ack_i in IDLE with cpu_req_i=0.
  - Required: no array, state or output change.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Sits between the MEM stage and a 256-bit line-wide memory port. Hits
// complete with no stall. A miss freezes the pipeline, writes back a dirty
// victim if needed, then refills the line and replays the access as a hit.
module dcache_ctrl #(
  parameter int LINES = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_write_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i,
  output logic [255:0] mem_data_o,
  output logic [31:0]  mem_addr_o,
  output logic         mem_enable_o,
  output logic         mem_write_o
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 32 - 5 - IW;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITEBACK,
    ST_GAP,
    ST_ALLOCATE
  } state_t;

  state_t state;

  // Line storage; data and tag carry no reset, valid/dirty do.
  logic [255:0]     data_q [LINES];
  logic [TW-1:0]    tag_q  [LINES];
  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;

  logic [2:0]    word_sel;
  logic [IW-1:0] idx;
  logic [TW-1:0] cpu_tag;
  logic [7:0]    word_lsb;
  logic          hit;
  logic          store_hit;
  logic          wb_done;
  logic          fill_done;
  logic          unused_addr_bits;

  assign word_sel = cpu_addr_i[4:2];
  assign idx      = cpu_addr_i[5 +: IW];
  assign cpu_tag  = cpu_addr_i[31 -: TW];
  assign word_lsb = {word_sel, 5'b0};

  // Byte offset within the word is irrelevant for 32-bit accesses.
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign hit       = cpu_req_i & valid_q[idx] & (tag_q[idx] == cpu_tag);
  assign store_hit = (state == ST_IDLE) & hit & cpu_write_i;
  assign wb_done   = (state == ST_WRITEBACK) & mem_ack_i;
  assign fill_done = (state == ST_ALLOCATE) & mem_ack_i;

  // Miss-handling sequencer; ack is only honoured while a transfer is open.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_req_i && !hit) begin
            state <= (valid_q[idx] && dirty_q[idx]) ? ST_WRITEBACK : ST_ALLOCATE;
          end
        end
        ST_WRITEBACK: if (mem_ack_i) state <= ST_GAP;
        ST_GAP:       state <= ST_ALLOCATE;
        ST_ALLOCATE:  if (mem_ack_i) state <= ST_IDLE;
        default:      state <= ST_IDLE;
      endcase
    end
  end

  // Line status bits; reset invalidates every line and drops any dirty data.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_done) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (wb_done) begin
      dirty_q[idx] <= 1'b0;
    end else if (store_hit) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Line payload: refill replaces the whole line, a store hit patches one word.
  always_ff @(posedge clk_i) begin
    if (fill_done) begin
      data_q[idx] <= mem_data_i;
      tag_q[idx]  <= cpu_tag;
    end else if (store_hit) begin
      data_q[idx][word_lsb +: 32] <= cpu_data_i;
    end
  end

  // Memory-side outputs decoded straight from the state register.
  always_comb begin
    mem_enable_o = (state == ST_WRITEBACK) || (state == ST_ALLOCATE);
    mem_write_o  = (state == ST_WRITEBACK);
    mem_data_o   = '0;
    mem_addr_o   = '0;
    case (state)
      ST_WRITEBACK: begin
        mem_addr_o = {tag_q[idx], idx, 5'b0};
        mem_data_o = data_q[idx];
      end
      ST_ALLOCATE:  mem_addr_o = {cpu_tag, idx, 5'b0};
      default: ;
    endcase
  end

  assign cpu_data_o  = data_q[idx][word_lsb +: 32];
  assign cpu_stall_o = (state != ST_IDLE) | (cpu_req_i & ~hit);

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: the stimulus side predicts memory
// transactions and CPU responses from a flat-memory reference plus a
// per-index residency table; a monitor pops and compares them.
module tb_dcache_ctrl;

  localparam int K_WB = 0;
  localparam int K_RD = 1;
  localparam int K_LD = 2;
  localparam int K_ST = 3;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         cpu_req_i = 1'b0;
  logic         cpu_write_i = 1'b0;
  logic [31:0]  cpu_addr_i = '0;
  logic [31:0]  cpu_data_i = '0;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i;
  logic [255:0] mem_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o;
  logic         mem_write_o;

  logic resp_ack = 1'b0;
  logic spur_ack = 1'b0;
  assign mem_ack_i = resp_ack | spur_ack;

  dcache_ctrl #(.LINES(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .mem_data_o(mem_data_o), .mem_addr_o(mem_addr_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           kind;
    logic [31:0]  addr;
    logic [255:0] data;
    bit           miss;
    bit           wb;
  } exp_t;

  exp_t txq[$];
  exp_t rsq[$];

  int checks = 0;
  int failures = 0;

  logic [255:0] backing [logic [31:0]];
  logic [31:0]  refmem  [logic [31:0]];
  bit           m_valid [32];
  bit           m_dirty [32];
  logic [31:0]  m_line  [32];

  int fixed_lat = -1;
  bit hold = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0F1E2D3C;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (refmem.exists(wa)) return refmem[wa];
    return init_word(wa);
  endfunction

  function automatic logic [255:0] ref_line(input logic [31:0] line);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = ref_rd(line + 32'(4*w));
    return l;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] line);
    logic [255:0] l;
    if (backing.exists(line)) return backing[line];
    for (int w = 0; w < 8; w++) l[32*w +: 32] = init_word(line + 32'(4*w));
    return l;
  endfunction

  // Memory responder: random (or forced) latency, one-cycle ack pulse.
  initial begin
    bit active;
    int cnt;
    active = 1'b0;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_i) begin
        resp_ack = 1'b0;
        active = 1'b0;
      end else if (resp_ack) begin
        resp_ack = 1'b0;
        active = 1'b0;
      end else if (mem_enable_o && !hold) begin
        if (!active) begin
          active = 1'b1;
          cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        end
        if (cnt == 0) begin
          if (mem_write_o) backing[mem_addr_o] = mem_data_o;
          else mem_data_i = mem_line(mem_addr_o);
          resp_ack = 1'b1;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Monitor: compares observed transfers and CPU completions with the queues.
  initial begin
    int stall_cnt;
    int en_cnt;
    int gap_st;
    int exp_stall;
    exp_t e;
    stall_cnt = 0;
    en_cnt = 0;
    gap_st = 0;
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        stall_cnt = 0;
        en_cnt = 0;
        gap_st = 0;
      end else begin
        if (mem_enable_o) en_cnt++;
        if (gap_st == 1) begin
          check("gap_enable_low", 256'(mem_enable_o), 256'(0));
          gap_st = 2;
        end else if (gap_st == 2) begin
          check("alloc_after_gap", 256'({mem_enable_o, mem_write_o}), 256'(2'b10));
          gap_st = 0;
        end
        if (!mem_enable_o) check("idle_wr_addr", 256'({mem_write_o, mem_addr_o}), 256'(0));
        if (!mem_write_o) check("nonwb_data", mem_data_o, 256'(0));
        if (mem_enable_o && mem_ack_i) begin
          if (txq.size() == 0) begin
            check("unexpected_txn", 256'(mem_addr_o), 256'hFFFF_FFFF_0);
          end else begin
            e = txq.pop_front();
            check("txn_write", 256'(mem_write_o), 256'(e.kind == K_WB));
            check("txn_addr", 256'(mem_addr_o), 256'(e.addr));
            if (e.kind == K_WB) begin
              check("wb_data", mem_data_o, e.data);
              gap_st = 1;
            end
          end
        end
        if (!cpu_req_i) check("stall_no_req", 256'(cpu_stall_o), 256'(0));
        if (cpu_req_i && cpu_stall_o) stall_cnt++;
        if (cpu_req_i && !cpu_stall_o) begin
          if (rsq.size() == 0) begin
            check("unexpected_resp", 256'(cpu_addr_i), 256'hFFFF_FFFF_0);
          end else begin
            e = rsq.pop_front();
            check("resp_kind", 256'(cpu_write_i), 256'(e.kind == K_ST));
            if (e.kind == K_LD) check("load_data", 256'(cpu_data_o), e.data);
            exp_stall = e.miss ? (en_cnt + 1 + (e.wb ? 1 : 0)) : 0;
            check("stall_cycles", 256'(stall_cnt), 256'(exp_stall));
          end
          stall_cnt = 0;
          en_cnt = 0;
        end
      end
    end
  end

  // Predict the access outcome, drive it, and wait for the stall to clear.
  task automatic access(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                        output int stalls);
    exp_t e;
    exp_t t;
    logic [31:0] line;
    int idx;
    line = {addr[31:5], 5'b0};
    idx = int'(addr[9:5]);
    e.miss = 1'b0;
    e.wb = 1'b0;
    e.data = '0;
    e.addr = addr;
    if (!(m_valid[idx] && m_line[idx] == line)) begin
      e.miss = 1'b1;
      if (m_valid[idx] && m_dirty[idx]) begin
        t.kind = K_WB; t.addr = m_line[idx]; t.data = ref_line(m_line[idx]);
        t.miss = 1'b0; t.wb = 1'b0;
        txq.push_back(t);
        e.wb = 1'b1;
      end
      t.kind = K_RD; t.addr = line; t.data = '0; t.miss = 1'b0; t.wb = 1'b0;
      txq.push_back(t);
      m_valid[idx] = 1'b1;
      m_line[idx] = line;
      m_dirty[idx] = 1'b0;
    end
    if (wr) begin
      refmem[{addr[31:2], 2'b00}] = wdata;
      m_dirty[idx] = 1'b1;
      e.kind = K_ST;
    end else begin
      e.kind = K_LD;
      e.data = 256'(ref_rd(addr));
    end
    rsq.push_back(e);
    cpu_req_i = 1'b1;
    cpu_write_i = wr;
    cpu_addr_i = addr;
    cpu_data_i = wdata;
    stalls = 0;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (!cpu_stall_o) break;
      stalls++;
      if (n > 200) begin
        failures++;
        $display("FAIL access_timeout addr=%0h stalls=%0d", addr, stalls);
        $fatal(1, "access did not complete");
      end
    end
    @(posedge clk);
    #1;
    cpu_req_i = 1'b0;
  endtask

  initial begin
    int s;
    logic [255:0] l;
    logic [31:0] a;
    #1 rst_i = 1'b0;
    #1;
    check("rst_enable", 256'(mem_enable_o), 256'(0));
    check("rst_write", 256'(mem_write_o), 256'(0));
    check("rst_addr", 256'(mem_addr_o), 256'(0));
    check("rst_data", mem_data_o, 256'(0));
    check("rst_stall_noreq", 256'(cpu_stall_o), 256'(0));
    cpu_req_i = 1'b1;
    cpu_addr_i = 32'h44;
    #1;
    check("rst_stall_req", 256'(cpu_stall_o), 256'(1));

    // Start a refill that memory never answers, then reset in the middle of it.
    hold = 1'b1;
    @(negedge clk) rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("alloc_started", 256'({mem_enable_o, mem_write_o, mem_addr_o}), 256'({2'b10, 32'h40}));
    rst_i = 1'b0;
    #1;
    check("midrst_enable", 256'(mem_enable_o), 256'(0));
    check("midrst_addr", 256'(mem_addr_o), 256'(0));
    cpu_req_i = 1'b0;
    @(negedge clk) rst_i = 1'b1;
    hold = 1'b0;
    @(posedge clk);
    #1;

    // Memory line 0x40 carries 0xDEADBEEF in word 1.
    l = mem_line(32'h40);
    l[63:32] = 32'hDEADBEEF;
    backing[32'h40] = l;
    refmem[32'h44] = 32'hDEADBEEF;

    fixed_lat = 2;
    access(32'h44, 1'b0, 32'h0, s);
    check("clean_miss_stalls", 256'(s), 256'(4));
    access(32'h40, 1'b0, 32'h0, s);
    check("read_hit_stalls", 256'(s), 256'(0));
    access(32'h44, 1'b1, 32'h12345678, s);
    check("store_hit_stalls", 256'(s), 256'(0));
    access(32'h444, 1'b0, 32'h0, s);
    access(32'h84, 1'b1, 32'hA5A5A5A5, s);
    access(32'h84, 1'b0, 32'h0, s);
    check("store_miss_reload_stalls", 256'(s), 256'(0));
    access(32'h884, 1'b0, 32'h0, s);
    check("backing_after_wb", 256'(backing[32'h80][63:32]), 256'(32'hA5A5A5A5));

    // Stray ack with no request must be ignored.
    spur_ack = 1'b1;
    mem_data_i = {8{32'hBAD0BAD0}};
    @(posedge clk);
    #1;
    spur_ack = 1'b0;
    check("spur_enable", 256'({mem_enable_o, cpu_stall_o}), 256'(0));
    access(32'h884, 1'b0, 32'h0, s);
    check("post_spurious_hit", 256'(s), 256'(0));

    fixed_lat = -1;
    for (int i = 0; i < 300; i++) begin
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 5)
        | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      access(a, 1'($urandom_range(0, 1)), $urandom, s);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("txq_drained", 256'(txq.size()), 256'(0));
    check("rsq_drained", 256'(rsq.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
